// File: rtl/chunked_wide_adder_pkg.sv
// Shared types and helpers for the chunked wide adder: FSM state encoding
// and the width function used to size the slice index counter.
package chunked_wide_adder_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Ceiling log2, floored at 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/chunked_wide_adder_slice_adder_ci.sv
// Combinational N-bit adder with carry-in; one instance serves every slice
// of the wide operation in turn.
module slice_adder_ci #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/chunked_wide_adder.sv
// Serial wide adder: accepts N-bit operand slices LSB first, chains the carry
// through a register and presents the full N*WORDS-bit sum with a handshake.
module chunked_wide_adder
  import chunked_wide_adder_pkg::*;
#(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_a,
  input  logic [N-1:0]       in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] out_sum,
  output logic               out_carry
);

  localparam int IW = clog2(WORDS);

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [N*WORDS-1:0] sum_q, sum_d;
  logic               out_carry_q, out_carry_d;

  logic [N-1:0]       slice_sum;
  logic               slice_cout;
  logic               accept;

  slice_adder_ci #(.N(N)) u_slice_adder (
    .a    (in_a),
    .b    (in_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign in_ready  = (state_q == ACC) && !rst;
  assign out_valid = (state_q == HOLD);
  assign out_sum   = sum_q;
  assign out_carry = out_carry_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the case leaves one unassigned and infers a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    out_carry_d = out_carry_q;

    unique case (state_q)
      ACC: begin
        if (accept) begin
          sum_d[idx_q*N +: N] = slice_sum;
          if (idx_q == IW'(WORDS - 1)) begin
            // Last slice: publish the overflow and clear the chain for the next op.
            out_carry_d = slice_cout;
            idx_d       = '0;
            carry_d     = 1'b0;
            state_d     = HOLD;
          end else begin
            carry_d = slice_cout;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      out_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      out_carry_q <= out_carry_d;
    end
  end

endmodule

// File: tb/tb_chunked_wide_adder.sv
// Self-checking bench for chunked_wide_adder: directed cases plus random
// operations compared against a plain wide-arithmetic reference.
module tb_chunked_wide_adder;

  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;

  int n_checks;
  int n_fail;
  int cyc;
  int last_first_accept;

  chunked_wide_adder #(.N(N), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one slice and return just after the edge that accepts it.
  task automatic send_slice(input logic [N-1:0] a, input logic [N-1:0] b, output int acc_cyc);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  // One full operation checked against plain (W+1)-bit arithmetic.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int gap, input int stall);
    logic [W:0]   ref_full;
    logic [W-1:0] held;
    int           acc_cyc;
    ref_full  = {1'b0, a} + {1'b0, b};
    out_ready = (stall == 0);
    for (int k = 0; k < WORDS; k++) begin
      if (k == WORDS - 1) check({tag, "_valid_early"}, 64'(out_valid), 64'd0);
      send_slice(a[k*N +: N], b[k*N +: N], acc_cyc);
      if (k == 0) last_first_accept = acc_cyc;
      if (k != WORDS - 1) idle(gap);
    end
    check({tag, "_valid_lat1"}, 64'(out_valid), 64'd1);
    check({tag, "_sum"}, 64'(out_sum), 64'(ref_full[W-1:0]));
    check({tag, "_carry"}, 64'(out_carry), 64'(ref_full[W]));
    held = out_sum;
    if (stall > 0) begin
      for (int s = 0; s < stall; s++) begin
        in_valid = 1'b1;
        in_a     = N'($urandom);
        in_b     = N'($urandom);
        idle(1);
        check({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_stall_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_stall_sum"}, 64'(out_sum), 64'(held));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    idle(1);
    check({tag, "_release_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_release_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int acc_cyc;
    int first_op1;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    last_first_accept = 0;
    idle(2);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_carry", 64'(out_carry), 64'd0);
    check("rst_in_ready_after", 64'(in_ready), 64'd1);

    run_op("slice_carry", 32'h0000_00FF, 32'h0000_0001, 0, 0);
    check("slice_carry_exact", 64'(out_sum), 64'h0000_0100);
    run_op("wrap_all", 32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
    run_op("wrap_msb", 32'h8000_0000, 32'h8000_0000, 0, 0);
    run_op("gapped", 32'h1234_5678, 32'h0F0F_0F0F, 1, 0);
    check("gapped_exact", 64'(out_sum), 64'h2143_6587);
    run_op("backpressure", 32'hDEAD_BEEF, 32'h0123_4567, 0, 5);

    // Abort an operation after two carry-generating slices.
    out_ready = 1'b1;
    send_slice(8'hFF, 8'h01, acc_cyc);
    send_slice(8'hFF, 8'h00, acc_cyc);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_a     = 8'h55;
    in_b     = 8'h55;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    idle(1);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_sum", 64'(out_sum), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    run_op("after_rst", 32'h0000_0002, 32'h0000_0003, 0, 0);
    check("after_rst_exact", 64'(out_sum), 64'h0000_0005);

    run_op("b2b_op1", 32'h0000_0001, 32'h0000_0001, 0, 0);
    first_op1 = last_first_accept;
    run_op("b2b_op2", 32'hAAAA_AAAA, 32'h5555_5555, 0, 0);
    check("b2b_period", 64'(last_first_accept - first_op1), 64'(WORDS + 1));
    check("b2b_op2_exact", 64'(out_sum), 64'hFFFF_FFFF);

    for (int i = 0; i < 25; i++) begin
      run_op("rand", W'($urandom), W'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
